// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and valid/ready imem handshake with stall/flush handling.
// Optional FETCH_STATS_EN adds stall_cycles / imem_wait_cycles counters and ports.
module fetch_stage #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            DATA_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_PC,
  input  logic              write_IFID,
  input  logic              take_branch,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_IFID,
  output logic [ADDR_W-1:0] pcPlus4_IFID,
  output logic              valid_IFID,
  output logic              fetch_busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       imem_wait_cycles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pcp4_q, pcp4_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign imem_req     = (state_q != HOLD);
  assign imem_addr    = pc_q;
  assign fetch_busy   = (state_q != FETCH);
  assign instr_IFID   = instr_q;
  assign pcPlus4_IFID = pcp4_q;
  assign valid_IFID   = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (take_branch) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
          end else if (write_IFID) begin
            instr_d = imem_rdata;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            if (write_PC) pc_d = pc_plus4;
          end else begin
            // Response arrived during a stall: park it so it is not refetched.
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end else if (take_branch) begin
          tgt_d   = branch_target;
          valid_d = 1'b0;
          state_d = DRAIN;
        end else if (write_IFID) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (take_branch) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (write_IFID) begin
          instr_d = buf_q;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
          if (write_PC) pc_d = pc_plus4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // Old request must complete at the old address; the latest branch wins.
        valid_d = 1'b0;
        if (take_branch) tgt_d = branch_target;
        if (imem_ready) begin
          pc_d    = take_branch ? branch_target : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      tgt_q   <= '0;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stall_q, wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      if (!write_IFID)              stall_q <= stall_q + 32'd1;
      if (imem_req && !imem_ready)  wait_q  <= wait_q + 32'd1;
    end
  end

  assign stall_cycles     = stall_q;
  assign imem_wait_cycles = wait_q;
`endif

endmodule
